// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: LANES bytes per cycle through replicated inverse S-box ROMs,
// valid/ready on both sides, result held in DONE until downstream accepts it.
module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned N  = 16 / LANES;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    // Inverse AES S-box, entry i is InvSbox(i)
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [127:0]    work;
    logic [127:0]    work_sub;
    logic [CW-1:0]   count;
    logic            last;
    logic [3:0]      base;
    logic [3:0]      lane_idx [LANES];
    logic [7:0]      lane_sub [LANES];
    logic            in_ready_d;
    logic            out_valid_d;
    logic            busy_d;

    // Reject lane counts that do not divide the 16-byte state
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    assign last = (count == CW'(N - 1));
    assign base = 4'(32'(count) * LANES);

    // One inverse S-box lookup per lane on the current byte window
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = base + 4'(l);
        assign lane_sub[l] = INV_SBOX[work[{lane_idx[l], 3'b000} +: 8]];
    end

    // Work register with the current window replaced by its substituted bytes
    always_comb begin
        work_sub = work;
        for (int l = 0; l < LANES; l++) begin
            work_sub[{lane_idx[l], 3'b000} +: 8] = lane_sub[l];
        end
    end

    // FSM state register; reset discards any operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output decode of the next state, so the handshake outputs are registered
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            IDLE:    in_ready_d  = 1'b1;
            BUSY:    busy_d      = 1'b1;
            DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d  = 1'b1;
        endcase
    end

    // Datapath and registered outputs; out_data is loaded only with a finished result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work      <= '0;
            count     <= '0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        count <= '0;
                    end
                end
                BUSY: begin
                    work  <= work_sub;
                    count <= count + CW'(1);
                    if (last) begin
                        out_data <= work_sub;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq; reference S-boxes are derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;

    localparam int unsigned LANES = 4;
    localparam int unsigned N     = 16 / LANES;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;
    logic         in_ready_l1, out_valid_l1, busy_l1;
    logic [127:0] out_data_l1;
    logic         in_ready_l16, out_valid_l16, busy_l16;
    logic [127:0] out_data_l16;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sb     [256];
    logic [7:0] inv_sb [256];

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(LANES)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    inv_sub_bytes_seq #(.LANES(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_l1), .in_data(in_data),
        .out_valid(out_valid_l1), .out_ready(out_ready), .out_data(out_data_l1), .busy(busy_l1)
    );

    inv_sub_bytes_seq #(.LANES(16)) u_dut_l16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_l16), .in_data(in_data),
        .out_valid(out_valid_l16), .out_ready(out_ready), .out_data(out_data_l16), .busy(busy_l16)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // Forward S-box = affine(multiplicative inverse); inverse table by inversion of that map
    function automatic void build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b, r, s;
            b = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
                end
            end
            s = b; r = b;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sb[x] = s ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_sb[sb[x]] = 8'(x);
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_sb[s[i*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        vectors++; if (out_data !== 128'h0) begin miscompares++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", busy); end
        reset_n = 1'b1;
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_known_vector();
        logic [127:0] d, e;
        int n;
        d = 128'hcb42d28f_dac4e23c_63636363_00000000;
        e = 128'h59f67f73_7a883b6d_00000000_52525252;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL kv_idle_ready: got %b exp 1", in_ready); end
        push(d);
        in_data = rand128();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL kv_busy_ready: got %b exp 0", in_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL kv_busy: got %b exp 1", busy); end
        wait_valid(n);
        vectors++; if (n != int'(N)) begin miscompares++; $display("FAIL kv_latency: got %0d exp %0d", n, N); end
        vectors++; if (out_data !== e) begin miscompares++; $display("FAIL kv_data: got %h exp %h", out_data, e); end
        tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL kv_release: got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d, e;
        int n;
        d = rand128(); e = model(d);
        out_ready = 1'b0;
        push(d);
        wait_valid(n);
        vectors++; if (n != int'(N)) begin miscompares++; $display("FAIL bp_latency: got %0d exp %0d", n, N); end
        in_valid = 1'b1;
        in_data  = rand128();
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b data=%h exp valid=1 ready=0 data=%h",
                         i, out_valid, in_ready, out_data, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release: got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] d, e;
        int n;
        out_ready = 1'b1;
        push(rand128());
        tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy: got %b exp 1", busy); end
        reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 128'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_busy: got valid=%b ready=%b busy=%b data=%h exp 0 1 0 0", out_valid, in_ready, busy, out_data);
        end
        tick();
        reset_n = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_after: got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
        d = rand128(); e = model(d);
        push(d);
        wait_valid(n);
        vectors++; if (n != int'(N)) begin miscompares++; $display("FAIL rst_new_latency: got %0d exp %0d", n, N); end
        vectors++; if (out_data !== e) begin miscompares++; $display("FAIL rst_new_data: got %h exp %h", out_data, e); end
        tick();
    endtask

    task automatic test_latency_sweep();
        int f1, f4, f16;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        out_ready = 1'b0;
        push({16{8'h63}});
        f1 = -1; f4 = -1; f16 = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (out_valid_l16 === 1'b1 && f16 < 0) f16 = c;
            if (out_valid === 1'b1 && f4 < 0) f4 = c;
            if (out_valid_l1 === 1'b1 && f1 < 0) f1 = c;
        end
        vectors++; if (f16 != 1) begin miscompares++; $display("FAIL sweep_lat16: got %0d exp 1", f16); end
        vectors++; if (f4 != int'(N)) begin miscompares++; $display("FAIL sweep_lat4: got %0d exp %0d", f4, N); end
        vectors++; if (f1 != 16) begin miscompares++; $display("FAIL sweep_lat1: got %0d exp 16", f1); end
        vectors++; if (out_data_l16 !== 128'h0) begin miscompares++; $display("FAIL sweep_data16: got %h exp 0", out_data_l16); end
        vectors++; if (out_data !== 128'h0) begin miscompares++; $display("FAIL sweep_data4: got %h exp 0", out_data); end
        vectors++; if (out_data_l1 !== 128'h0) begin miscompares++; $display("FAIL sweep_data1: got %h exp 0", out_data_l1); end
        out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || out_valid_l1 !== 1'b0 || out_valid_l16 !== 1'b0) begin
            miscompares++; $display("FAIL sweep_release: got %b%b%b exp 000", out_valid_l1, out_valid, out_valid_l16);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] st [3];
        logic [127:0] ex [3];
        int   cyc, sent, got, last_acc;
        logic acc;
        for (int k = 0; k < 3; k++) begin
            st[k] = rand128();
            st[k][7:0] = 8'(k);
            ex[k] = model(st[k]);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = st[0];
        cyc = 0; sent = 0; got = 0; last_acc = 0;
        while (got < 3 && cyc < 100) begin
            acc = (in_valid === 1'b1) && (in_ready === 1'b1);
            if (out_valid === 1'b1) begin
                vectors++; if (out_data !== ex[got]) begin
                    miscompares++; $display("FAIL b2b_data[%0d]: got %h exp %h", got, out_data, ex[got]);
                end
                got++;
            end
            tick();
            cyc++;
            if (acc && sent < 3) begin
                if (sent > 0) begin
                    vectors++; if (cyc - last_acc != int'(N) + 2) begin
                        miscompares++; $display("FAIL b2b_spacing[%0d]: got %0d exp %0d", sent, cyc - last_acc, N + 2);
                    end
                end
                last_acc = cyc;
                sent++;
                if (sent < 3) in_data = st[sent];
                else          in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        vectors++; if (got != 3 || sent != 3) begin
            miscompares++; $display("FAIL b2b_count: got out=%0d acc=%0d exp 3 3", got, sent);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] d, e;
        int n;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) begin
                d[i*8 +: 8] = sb[16*k + i];
                e[i*8 +: 8] = 8'(16*k + i);
            end
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rt_ready[%0d]: got %b exp 1", k, in_ready); end
            push(d);
            wait_valid(n);
            vectors++; if (n != int'(N) || out_data !== e) begin
                miscompares++; $display("FAIL rt_data[%0d]: got lat=%0d data=%h exp lat=%0d data=%h", k, n, out_data, N, e);
            end
            tick();
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_known_vector();
        test_backpressure();
        test_reset_mid_busy();
        test_latency_sweep();
        test_back_to_back();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
